pipe_stage_latch: RTL
=====================

# pipe_stage_latch

Parametrised elastic pipeline latch for inter-stage boundaries in each core (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a packed payload of configurable width under a valid/ready handshake, and a 2-entry skid buffer sustains one transfer per cycle without a combinational ready path from downstream. It keeps the freeze and flush controls of the existing fixed latches and adds backpressure, bubble insertion and optional occupancy statistics.

## Interface
- `WIDTH`, 128: payload width in bits (instr, npc, rdat1/2, control fields packed by the instantiating stage).
- `BUBBLE`, `'0`: payload value presented when no entry is valid. Decodes as a NOP with all write enables low.
- `CNT_W`, 32: statistics counter width.
- `CLK`  in  1  rising-edge clock.
- `RST`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  latch can accept this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  downstream accepts head.
- `out_data`  out  WIDTH  head payload, or `BUBBLE` when empty.
- `freeze`  in  1  hold all state (hazard stall).
- `flush`  in  1  discard all entries (branch/jump resolve).
- `stall_cnt`  out  CNT_W  statistics (see Configuration).
- `bubble_cnt`  out  CNT_W  statistics (see Configuration).

## Operation
- Storage has two slots:
  - `main` is the head and drives `out_data`.
  - `skid` is the overflow slot.
- Occupancy state is one of EMPTY, ONE, or FULL.
- Signal definitions:
  - `accept` = `in_valid & in_ready`.
  - `fire` = `out_valid & out_ready & ~freeze`.
  - `in_ready` = (state != FULL) & ~freeze & ~flush. This is combinational from registered state plus freeze/flush only; it never depends on `out_ready`.
  - `out_valid` = (state != EMPTY).
  - `out_data` = `main` when valid, else `BUBBLE`.
- State transitions:
  - EMPTY: accept → ONE, with `main` ← `in_data`.
  - ONE:
    - accept & fire → ONE, with `main` ← `in_data`.
    - accept & ~fire → FULL, with `skid` ← `in_data`.
    - fire & ~accept → EMPTY.
  - FULL: fire → ONE, with `main` ← `skid`. No accept is possible.
- Priority (highest first):
  1. `RST` → EMPTY.
  2. `flush` → EMPTY. Any same-cycle `in_data` is dropped and does not fire, even if `out_ready` is high.
  3. `freeze` → state and slots are held. `out_valid` and `out_data` keep their values.
  4. Normal transfer.
- `flush` and `freeze` asserted together: flush wins, so the latch empties.
- Payload bits are never inspected or modified.

## Timing
- Reset values:
  - `out_valid`=0
  - `out_data`=`BUBBLE`
  - `in_ready`=1 (unless freeze/flush)
  - counters=0
  - state EMPTY
- Latency: an accept in cycle N gives `out_valid`=1 with that payload in cycle N+1.
- Throughput: 1 transfer/cycle sustained when `out_ready` is held high. Steady state sits at ONE.
- Backpressure: with `out_ready` low from ONE, one further beat is absorbed into `skid`, and `in_ready` drops in the next cycle.
- Order is strictly FIFO: `skid` never overtakes `main`.
- Flush in cycle N gives `out_valid`=0 and `out_data`=`BUBBLE` in cycle N+1.
- Reset mid-transfer discards both slots with no partial state.

## Configuration
- Macro: `PIPE_STAGE_STATS_EN`.
- Defined:
  - `stall_cnt` increments each cycle with `out_valid & (~out_ready | freeze)`.
  - `bubble_cnt` increments each cycle with `~out_valid`.
  - Both saturate at all-ones, clear only on `RST`, and are unaffected by flush.
- Undefined: both ports are tied to 0 and no counter flops are synthesised. All other behaviour is identical.

## Structure
- `cpu_types_pkg` gains:
  - `pipe_occ_t` enum (EMPTY, ONE, FULL).
  - Default bubble constant `PIPE_BUBBLE_WORD`.
- The per-stage packed payload structs (`id_ex_pkt_t`, etc.) also live in `cpu_types_pkg`. Instantiating stages cast them to and from `WIDTH`.
- Sub-module `pipe_slot`: a `WIDTH`-bit register with load enable and synchronous clear-to-`BUBBLE`, instantiated twice (`main`, `skid`).
- Statistics logic stays inline under the macro.

## Test plan
- Reset then idle:
  - Expect `out_valid`=0, `out_data`=`BUBBLE`, `in_ready`=1.
  - Expect counters 0, and with stats on, `bubble_cnt` increments by 1 per idle cycle.
- Streaming:
  - Send payloads 1,2,3,4 back-to-back with `out_ready`=1.
  - Expect outputs 1,2,3,4 in cycles N+1..N+4 with no gap, and `in_ready` constantly 1.
- Backpressure:
  - Send 0xA in cycle N, drop `out_ready` in N+1, send 0xB in N+1.
  - Expect FULL, with `in_ready`=0 in N+2.
  - Raise `out_ready` in N+3: expect 0xA then 0xB, and `in_ready`=1 again in N+4.
- Freeze:
  - In state ONE holding 0x55, assert `freeze` 3 cycles with `out_ready`=1.
  - Expect `out_data` held at 0x55, no fire, `in_ready`=0.
  - With stats on, expect `stall_cnt` +3.
- Flush priority:
  - With FULL holding 0xA/0xB, assert `flush` and `freeze` together while `in_valid`=1 with 0xC.
  - Next cycle expect EMPTY, `out_data`=`BUBBLE`, and 0xC never output.
- Mid-stream reset:
  - Assert `RST` while FULL and `in_valid`=1.
  - Next cycle expect EMPTY with all reset values, and the stream restarting cleanly.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: pipeline latch occupancy encoding, the default bubble word,
// and the per-stage packed payload structs carried through pipe_stage_latch.
package cpu_types_pkg;

   // Occupancy of an elastic pipeline latch (main + skid slots).
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } pipe_occ_t;

   localparam int PIPE_WORD_W = 128;

   // All-zero payload decodes as a NOP with every write enable low.
   localparam logic [PIPE_WORD_W-1:0] PIPE_BUBBLE_WORD = '0;

   // ID/EX payload; stages cast it to and from the latch's WIDTH-bit word.
   typedef struct packed {
      logic [31:0] npc;
      logic [31:0] rdat1;
      logic [31:0] rdat2;
      logic [15:0] imm;
      logic [4:0]  rd;
      logic [10:0] ctrl;
   } id_ex_pkt_t;

   // True while the latch still has a free slot.
   function automatic logic pipe_has_room(pipe_occ_t occ);
      return occ != OCC_FULL;
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload slot of pipe_stage_latch: WIDTH-bit register with load enable
// and synchronous clear-to-BUBBLE.
module pipe_slot #(
   parameter int               WIDTH  = 128,
   parameter logic [WIDTH-1:0] BUBBLE = '0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Slot register: clear wins over load.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; the payload is also reset so no stale word survives RST.
   always_ff @(posedge CLK) begin
      if (RST || clr) begin
         q <= BUBBLE;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_latch.sv
// Elastic pipeline latch for inter-stage boundaries: valid/ready handshake,
// 2-entry skid buffer (main = head, skid = overflow), freeze and flush.
// in_ready depends only on registered occupancy plus freeze/flush, never on
// out_ready. Optional occupancy statistics are built when the macro
// PIPE_STAGE_STATS_EN is defined; otherwise the counter ports are tied to 0.
module pipe_stage_latch
   import cpu_types_pkg::*;
#(
   parameter int               WIDTH  = 128,
   parameter logic [WIDTH-1:0] BUBBLE = '0,
   parameter int               CNT_W  = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             freeze,
   input  logic             flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   pipe_occ_t        state, state_d;
   logic             accept, fire;
   logic             main_load, main_from_skid, skid_load, slot_clr;
   logic [WIDTH-1:0] main_q, skid_q, main_d;

   assign in_ready  = pipe_has_room(state) & ~freeze & ~flush;
   assign out_valid = (state != OCC_EMPTY);
   assign accept    = in_valid & in_ready;
   assign fire      = out_valid & out_ready & ~freeze;
   assign out_data  = out_valid ? main_q : BUBBLE;
   assign main_d    = main_from_skid ? skid_q : in_data;

   // Next occupancy and slot controls: flush beats freeze beats normal transfer.
   // NOTE: every signal gets a default first so no latch is inferred.
   always_comb begin
      state_d        = state;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      slot_clr       = 1'b0;
      if (flush) begin
         state_d  = OCC_EMPTY;
         slot_clr = 1'b1;
      end else if (!freeze) begin
         unique case (state)
            OCC_EMPTY: begin
               if (accept) begin
                  state_d   = OCC_ONE;
                  main_load = 1'b1;
               end
            end
            OCC_ONE: begin
               if (accept && fire) begin
                  main_load = 1'b1;
               end else if (accept) begin
                  state_d   = OCC_FULL;
                  skid_load = 1'b1;
               end else if (fire) begin
                  state_d = OCC_EMPTY;
               end
            end
            OCC_FULL: begin
               if (fire) begin
                  state_d        = OCC_ONE;
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
               end
            end
            default: state_d = OCC_EMPTY;
         endcase
      end
   end

   // Occupancy register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= OCC_EMPTY;
      end else begin
         state <= state_d;
      end
   end

   pipe_slot #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_main (
      .CLK  (CLK),
      .RST  (RST),
      .clr  (slot_clr),
      .load (main_load),
      .d    (main_d),
      .q    (main_q)
   );

   pipe_slot #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_skid (
      .CLK  (CLK),
      .RST  (RST),
      .clr  (slot_clr),
      .load (skid_load),
      .d    (in_data),
      .q    (skid_q)
   );

`ifdef PIPE_STAGE_STATS_EN
   logic [CNT_W-1:0] stall_q, bubble_q;

   // Saturating statistics; cleared only by RST, flush does not touch them.
   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         if (out_valid && (!out_ready || freeze) && !(&stall_q)) begin
            stall_q <= stall_q + CNT_W'(1);
         end
         if (!out_valid && !(&bubble_q)) begin
            bubble_q <= bubble_q + CNT_W'(1);
         end
      end
   end

   assign stall_cnt  = stall_q;
   assign bubble_cnt = bubble_q;
`else
   assign stall_cnt  = '0;
   assign bubble_cnt = '0;
`endif

endmodule
